// File: rtl/soc_pkg.sv
// -----------------------------------------------------------------------------
// soc_pkg -- shared constants for the soc instruction-fetch/decode demo.
//   * RV32 base opcode values for the ten instruction classes
//   * NOP reset value for the instruction register
//   * bit positions of each status flag on the LEDS display
//   * op_class_t: one-hot class flags produced by the decoder
//   * rom_word(): contents of the preloaded program ROM
// No ports (package).
// -----------------------------------------------------------------------------
package soc_pkg;

  localparam logic [6:0] OP_ALUREG = 7'b0110011;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // add x0, x0, x0
  localparam logic [31:0] NOP = 32'h0000_0033;

  localparam int LED_PC0    = 7;
  localparam int LED_UPPER  = 6;  // LUI | AUIPC
  localparam int LED_JUMP   = 5;  // JAL | JALR
  localparam int LED_BRANCH = 4;
  localparam int LED_STORE  = 3;
  localparam int LED_LOAD   = 2;
  localparam int LED_ALUIMM = 1;
  localparam int LED_ALUREG = 0;

  typedef struct packed {
    logic alu_reg;
    logic alu_imm;
    logic branch;
    logic jalr;
    logic jal;
    logic auipc;
    logic lui;
    logic load;
    logic store;
    logic system;
  } op_class_t;

  // Program image; every word past the listed ones is ebreak so the core
  // always ends up frozen regardless of ROM depth.
  function automatic logic [31:0] rom_word(input int unsigned idx);
    logic [31:0] w;
    if (idx == 0)                  w = 32'h0000_0033;  // add  x0,x0,x0
    else if (idx == 1)             w = 32'h0000_00B3;  // add  x1,x0,x0
    else if (idx >= 2 && idx <= 5) w = 32'h0010_8093;  // addi x1,x1,1
    else if (idx == 6)             w = 32'h0000_8133;  // add  x2,x1,x0
    else if (idx == 7)             w = 32'h0020_81B3;  // add  x3,x1,x2
    else if (idx == 8)             w = 32'h0031_D193;  // srli x3,x3,3
    else if (idx == 9)             w = 32'h01F1_9193;  // slli x3,x3,31
    else if (idx == 10)            w = 32'h4051_D193;  // srai x3,x3,5
    else if (idx == 11)            w = 32'h01A1_D093;  // srli x1,x3,26
    else if (idx == 12)            w = 32'h0000_A103;  // lw   x2,0(x1)
    else if (idx == 13)            w = 32'h0020_A023;  // sw   x2,0(x1)
    else                           w = 32'h0010_0073;  // ebreak
    return w;
  endfunction

endpackage

// File: rtl/soc_if.sv
// -----------------------------------------------------------------------------
// soc_if -- timing link between the clock/reset block and the core.
//   step : one-cycle enable; the core fetches one instruction per step
// Modports:
//   master : driven by clockworks
//   slave  : consumed by the soc core
// -----------------------------------------------------------------------------
interface soc_if;
  logic step;

  modport master (output step);
  modport slave  (input  step);
endinterface

// File: rtl/soc_clockworks.sv
// -----------------------------------------------------------------------------
// clockworks -- reset release synchronizer and step-tick generator.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset (board pin)
//   tick  : soc_if.master, carries the step enable
// Macro BENCH_EN: when defined the divider is bypassed and step is high on
// every cycle after reset release; otherwise step pulses once every
// 2^CLK_DIV_BITS cycles.
// -----------------------------------------------------------------------------
module clockworks #(
  parameter int CLK_DIV_BITS = 21
) (
  input  logic clk,
  input  logic rst_n,
  soc_if.master tick
);

  // Assertion is immediate, release is retimed through two flops so that
  // the step logic never sees a metastable reset edge.
  logic rst_meta_q, rst_meta_d;
  logic rst_sync_q, rst_sync_d;

  always_comb begin
    rst_meta_d = 1'b1;
    rst_sync_d = rst_meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= rst_meta_d;
      rst_sync_q <= rst_sync_d;
    end
  end

`ifdef BENCH_EN
  localparam int unused_div_bits = CLK_DIV_BITS;

  assign tick.step = rst_sync_q;
`else
  logic [CLK_DIV_BITS-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q;
    if (rst_sync_q) begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // Terminal count gives exactly one step per divider period.
  assign tick.step = rst_sync_q && (div_q == '1);
`endif

endmodule

// File: rtl/soc.sv
// -----------------------------------------------------------------------------
// soc -- minimal RV32 fetch/decode demonstrator driving a LED status display.
// Ports:
//   CLK   : system clock, all state on rising edge
//   RESET : asynchronous active-low reset
//   LEDS  : decoded-class display (8'hFF once an ebreak is reached)
//   RXD   : UART receive, ignored
//   TXD   : UART transmit, held idle high
// Parameters: MEM_WORDS (ROM depth), CLK_DIV_BITS (step divider width).
// Macro BENCH_EN: step every clock and print a trace line per step.
// -----------------------------------------------------------------------------
module soc
  import soc_pkg::*;
#(
  parameter int MEM_WORDS    = 32,
  parameter int CLK_DIV_BITS = 21
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic [7:0] LEDS,
  input  logic       RXD,
  output logic       TXD
);

  soc_if tick ();

  clockworks #(
    .CLK_DIV_BITS(CLK_DIV_BITS)
  ) u_clockworks (
    .clk  (CLK),
    .rst_n(RESET),
    .tick (tick)
  );

  // Program ROM, read only through the registered instr fetch below.
  logic [31:0] mem [MEM_WORDS];

  for (genvar gi = 0; gi < MEM_WORDS; gi++) begin : g_rom
    assign mem[gi] = rom_word(gi);
  end

  logic [4:0]  pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  op_class_t   cls;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    // A decoded SYSTEM instruction halts fetch until the next reset.
    if (tick.step && !cls.system) begin
      instr_d = mem[pc_q];
      pc_d    = (int'(pc_q) == MEM_WORDS - 1) ? 5'd0 : pc_q + 5'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc_q    <= 5'd0;
      instr_q <= NOP;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Decoder
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign funct3 = instr_q[14:12];
  assign funct7 = instr_q[31:25];

  assign imm_i = {{21{instr_q[31]}}, instr_q[30:20]};
  assign imm_s = {{21{instr_q[31]}}, instr_q[30:25], instr_q[11:7]};
  assign imm_b = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u = {instr_q[31:12], 12'b0};
  assign imm_j = {{12{instr_q[31]}}, instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

  always_comb begin
    cls = '0;
    case (opcode)
      OP_ALUREG: cls.alu_reg = 1'b1;
      OP_ALUIMM: cls.alu_imm = 1'b1;
      OP_BRANCH: cls.branch  = 1'b1;
      OP_JALR:   cls.jalr    = 1'b1;
      OP_JAL:    cls.jal     = 1'b1;
      OP_AUIPC:  cls.auipc   = 1'b1;
      OP_LUI:    cls.lui     = 1'b1;
      OP_LOAD:   cls.load    = 1'b1;
      OP_STORE:  cls.store   = 1'b1;
      OP_SYSTEM: cls.system  = 1'b1;
      default:   cls = '0;
    endcase
  end

  // Display depends only on pc_q/instr_q, never on the input pins.
  always_comb begin
    LEDS = 8'h00;
    if (cls.system) begin
      LEDS = 8'hFF;
    end else begin
      LEDS[LED_PC0]    = pc_q[0];
      LEDS[LED_UPPER]  = cls.lui | cls.auipc;
      LEDS[LED_JUMP]   = cls.jal | cls.jalr;
      LEDS[LED_BRANCH] = cls.branch;
      LEDS[LED_STORE]  = cls.store;
      LEDS[LED_LOAD]   = cls.load;
      LEDS[LED_ALUIMM] = cls.alu_imm;
      LEDS[LED_ALUREG] = cls.alu_reg;
    end
  end

  assign TXD = 1'b1;

  // Fields and immediates are decoded for future execute stages; fold them
  // together with the idle UART input so nothing dangles.
  logic unused_decode;
  assign unused_decode = ^{rd, rs1, rs2, funct3, funct7,
                           imm_i, imm_s, imm_b, imm_u, imm_j, RXD};

`ifdef BENCH_EN
  always @(posedge CLK) begin
    if (RESET && tick.step && !cls.system) begin
      $display("soc step: pc=%0d instr=%h class=%b", pc_q, instr_q, cls);
    end
  end
`endif

endmodule

// File: tb/tb_soc.sv
`timescale 1ns/1ps
module tb_soc;

  localparam int STEP_BUDGET = 64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] leds;
  logic       txd;

  int n_checks = 0;
  int n_pass   = 0;

  // Small divider so steps arrive quickly whether or not BENCH_EN is set.
  soc #(
    .MEM_WORDS   (32),
    .CLK_DIV_BITS(3)
  ) dut (
    .CLK  (clk),
    .RESET(reset_n),
    .LEDS (leds),
    .RXD  (rxd),
    .TXD  (txd)
  );

  always #5 clk = ~clk;

  // Random UART noise on the ignored input for the whole run.
  initial begin
    forever begin
      @(negedge clk);
      rxd = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [31:0] prog [32];
  int          m_pc;
  logic [31:0] m_instr;

  task automatic load_program();
    for (int i = 0; i < 32; i++) prog[i] = 32'h0010_0073;
    prog[0]  = 32'h0000_0033;
    prog[1]  = 32'h0000_00B3;
    for (int i = 2; i <= 5; i++) prog[i] = 32'h0010_8093;
    prog[6]  = 32'h0000_8133;
    prog[7]  = 32'h0020_81B3;
    prog[8]  = 32'h0031_D193;
    prog[9]  = 32'h01F1_9193;
    prog[10] = 32'h4051_D193;
    prog[11] = 32'h01A1_D093;
    prog[12] = 32'h0000_A103;
    prog[13] = 32'h0020_A023;
  endtask

  function automatic logic [7:0] model_leds(input logic [31:0] ins, input int pc);
    logic [6:0] op;
    logic [7:0] l;
    op = ins[6:0];
    if (op == 7'b1110011) return 8'hFF;
    l = 8'h00;
    l[7] = pc[0];
    case (op)
      7'b0110011:             l[0] = 1'b1;
      7'b0010011:             l[1] = 1'b1;
      7'b0000011:             l[2] = 1'b1;
      7'b0100011:             l[3] = 1'b1;
      7'b1100011:             l[4] = 1'b1;
      7'b1100111, 7'b1101111: l[5] = 1'b1;
      7'b0010111, 7'b0110111: l[6] = 1'b1;
      default:                l = l;
    endcase
    return l;
  endfunction

  task automatic model_reset();
    m_pc    = 0;
    m_instr = 32'h0000_0033;
  endtask

  task automatic model_step();
    if (m_instr[6:0] != 7'b1110011) begin
      m_instr = prog[m_pc];
      m_pc    = (m_pc + 1) % 32;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Each executed step changes LEDS (PC[0] toggles, or the halt shows FF),
  // so a step is recognised as the next change of the display.
  task automatic run_steps(input int n, input string tag);
    logic [7:0] prev;
    logic [7:0] exp;
    int cyc;
    for (int s = 1; s <= n; s++) begin
      prev = model_leds(m_instr, m_pc);
      model_step();
      exp = model_leds(m_instr, m_pc);
      cyc = 0;
      do begin
        @(posedge clk);
        #1;
        cyc++;
      end while (leds === prev && cyc < STEP_BUDGET);
      n_checks++;
      if (leds === prev) begin
        $display("FAIL %s step %0d: timeout, leds stayed %02h, required %02h", tag, s, leds, exp);
      end else if (leds !== exp) begin
        $display("FAIL %s step %0d: leds=%02h required %02h", tag, s, leds, exp);
      end else begin
        n_pass++;
        $display("%s step %0d: pc=%0d leds=%02h", tag, s, m_pc, leds);
      end
    end
  endtask

  task automatic pulse_reset(input string tag);
    int hold;
    hold = $urandom_range(1, 5);
    @(negedge clk);
    #($urandom_range(1, 3));
    reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (leds !== 8'h01) $display("FAIL %s async reset: leds=%02h required 01", tag, leds);
    else begin n_pass++; $display("%s reset asserted: leds=%02h", tag, leds); end
    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (leds !== 8'h01) $display("FAIL %s reset hold cycle %0d: leds=%02h required 01", tag, c, leds);
      else n_pass++;
    end
    release_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (leds !== 8'h01) $display("FAIL reset leds: leds=%02h required 01", leds);
    else begin n_pass++; $display("reset: leds=%02h", leds); end
    n_checks++;
    if (txd !== 1'b1) $display("FAIL reset txd: txd=%b required 1", txd);
    else begin n_pass++; $display("reset: txd=%b", txd); end
  endtask

  task automatic test_program();
    release_reset();
    run_steps(15, "program");
  endtask

  task automatic test_frozen();
    logic [7:0] exp;
    exp = model_leds(m_instr, m_pc);
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (leds !== exp) $display("FAIL frozen cycle %0d: leds=%02h required %02h", c, leds, exp);
      else n_pass++;
      n_checks++;
      if (txd !== 1'b1) $display("FAIL frozen txd cycle %0d: txd=%b required 1", c, txd);
      else n_pass++;
    end
    $display("frozen: 100 cycles checked at leds=%02h", exp);
  endtask

  task automatic test_reset_while_frozen();
    pulse_reset("frozen_reset");
    run_steps(5, "after_frozen_reset");
  endtask

  task automatic test_mid_reset();
    // Pulse at step 7 as in the reference scenario, then rerun the whole program.
    pulse_reset("mid_reset7");
    run_steps(7, "pre_reset7");
    pulse_reset("mid_reset7");
    run_steps(15, "rerun7");
  endtask

  task automatic test_random_reset();
    int at;
    for (int r = 0; r < 3; r++) begin
      at = $urandom_range(1, 14);
      pulse_reset("rand_reset");
      run_steps(at, "rand_pre");
      pulse_reset("rand_reset");
      run_steps(15, "rand_rerun");
      test_frozen();
    end
  endtask

  initial begin
    load_program();
    test_reset();
    test_program();
    test_frozen();
    test_reset_while_frozen();
    test_mid_reset();
    test_random_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
